mem_write_arbiter: RTL and testbench
====================================

Name: mem_write_arbiter

Overview:
- Shares one data-memory write port between num_req ALU cores.
- Each core presents a write request (address, data) with valid/ready. The arbiter grants one request per cycle in round-robin order and holds it in a single registered output slot until memory accepts it.
- Sits between the ALU core array and the data-memory write port.
- Gives each core's MEM_WRITE path the ready handshake it needs to retire a store.

Parameters:
- num_req, 4, number of requesting cores (2..16).
- mem_addr_width, 16, width of a memory address.
- width, 32, width of write data (one register).
- cnt_width, 16, width of the accepted-write counter.

Ports:
- clk_i  input  1  clock.
- reset_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  num_req  per-core write request valid.
- req_addr_i  input  num_req*mem_addr_width  per-core address, core k at bits [k*mem_addr_width +: mem_addr_width].
- req_data_i  input  num_req*width  per-core data, same packing.
- req_ready_o  output  num_req  per-core accept; one-hot or zero.
- mem_valid_o  output  1  output slot holds a write.
- mem_addr_o  output  mem_addr_width  write address.
- mem_data_o  output  width  write data.
- mem_ready_i  input  1  memory accepts the slot this cycle.
- grant_idx_o  output  $clog2(num_req)  source core of the current slot.
- write_count_o  output  cnt_width  writes accepted by memory since reset.

Behaviour:
- Reset (async assert, sync release to clk_i):
  - mem_valid_o=0, mem_addr_o=0, mem_data_o=0, grant_idx_o=0, write_count_o=0.
  - Round-robin pointer rr_ptr=0, so core 0 has highest priority first.
  - req_ready_o=0 while reset_ni=0.
- Slot states: EMPTY (mem_valid_o=0) and FULL (mem_valid_o=1).
- can_load = EMPTY or (FULL and mem_ready_i).
- Arbitration (combinational):
  - Search req_valid_i starting at rr_ptr, wrapping num_req-1 -> 0.
  - The first set bit is the winner w.
  - req_ready_o[w]=can_load. All other bits are 0.
  - No valid requests: req_ready_o=0.
  - req_ready_o may depend combinationally on req_valid_i and mem_ready_i. It never depends on req_addr_i or req_data_i.
- Load (rising edge, winner exists and can_load):
  - mem_addr_o<=req_addr_i[w], mem_data_o<=req_data_i[w], grant_idx_o<=w, mem_valid_o<=1.
  - rr_ptr<=(w+1) mod num_req.
- Drain (FULL, mem_ready_i=1, no winner):
  - mem_valid_o<=0. Address, data and grant_idx_o hold their values.
- Stall (FULL, mem_ready_i=0):
  - mem_addr_o, mem_data_o and grant_idx_o hold stable. No req_ready_o asserted.
- Throughput and latency:
  - Back-to-back accept and load in the same cycle gives 1 write per cycle.
  - Latency from request accept to mem_valid_o is 1 cycle.
- Counter:
  - write_count_o increments by 1 on every cycle with mem_valid_o and mem_ready_i both high.
  - Wraps modulo 2^cnt_width.
- rr_ptr advances only on a load. Idle cycles and stalls leave it unchanged.
- Fairness: a continuously valid requester is granted within num_req loads.
- Requester rules:
  - Once req_valid_i[k] rises, req_valid_i[k], req_addr_i[k] and req_data_i[k] are held until req_ready_o[k]=1.
  - Dropping valid early is a protocol violation. Assert it in simulation only.
- Memory rules:
  - mem_ready_i when mem_valid_o=0 is ignored: no count and no state change.
- Reset mid-operation:
  - Any slot contents are discarded, with no write issued after reset asserts.
  - The in-flight requester is not acked. It keeps valid high and is re-arbitrated after reset.
- Single requester (num_req=2 with one idle): that core is granted every cycle memory is ready.

Test Plan:
1. Reset, all valids 0 for 5 cycles -> mem_valid_o=0, req_ready_o=0, write_count_o=0.
2. Core 2 requests addr 0x0040 / data 0xDEADBEEF, mem_ready_i=1:
   - req_ready_o=4'b0100 in cycle 0.
   - Cycle 1: mem_valid_o=1, mem_addr_o=0x0040, grant_idx_o=2.
   - Cycle 2: write_count_o=1.
3. All 4 cores request continuously with distinct addresses 0x10..0x13, mem_ready_i=1:
   - Grant order 0,1,2,3,0,...
   - One write per cycle.
   - write_count_o=8 after 8 accepted writes.
4. Core 1 granted, mem_ready_i=0 for 3 cycles:
   - mem_addr_o and mem_data_o stable.
   - req_ready_o=0 while stalled, with cores 0 and 3 valid.
   - On ready, the next load grants core 3, since rr_ptr=2.
5. Slot FULL, reset_ni pulsed low mid-stall -> mem_valid_o drops immediately (async), rr_ptr=0, write_count_o=0; the pending core is re-granted after release.
6. cnt_width=4, issue 17 writes -> write_count_o wraps to 1.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one data-memory write port between num_req cores.
// A single registered slot holds the granted write until memory takes it.
module mem_write_arbiter #(
  parameter int num_req        = 4,
  parameter int mem_addr_width = 16,
  parameter int width          = 32,
  parameter int cnt_width      = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [num_req-1:0]                req_valid_i,
  input  logic [num_req*mem_addr_width-1:0] req_addr_i,
  input  logic [num_req*width-1:0]          req_data_i,
  output logic [num_req-1:0]                req_ready_o,
  output logic                              mem_valid_o,
  output logic [mem_addr_width-1:0]         mem_addr_o,
  output logic [width-1:0]                  mem_data_o,
  input  logic                              mem_ready_i,
  output logic [$clog2(num_req)-1:0]        grant_idx_o,
  output logic [cnt_width-1:0]              write_count_o
);
  localparam int iw = $clog2(num_req);

  logic [num_req-1:0][mem_addr_width-1:0] addr_v;
  logic [num_req-1:0][width-1:0]          data_v;
  logic [iw-1:0]                          rr_ptr;
  logic [iw-1:0]                          win;
  logic [iw-1:0]                          win_nxt;
  logic [iw:0]                            idx;
  logic                                   found;
  logic                                   can_load;
  logic                                   load;

  // packed 2-D arrays share the flat bus layout, core k at slice k
  assign addr_v = req_addr_i;
  assign data_v = req_data_i;

  // first valid core at or after rr_ptr, wrapping at num_req
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < num_req; i++) begin
      idx = {1'b0, rr_ptr} + (iw+1)'(i);
      if (idx >= (iw+1)'(num_req)) idx = idx - (iw+1)'(num_req);
      if (!found && req_valid_i[idx[iw-1:0]]) begin
        found = 1'b1;
        win   = idx[iw-1:0];
      end
    end
  end

  assign can_load = !mem_valid_o || mem_ready_i;
  assign load     = found && can_load;
  assign win_nxt  = (win == iw'(num_req-1)) ? '0 : win + iw'(1);

  always_comb begin
    req_ready_o = '0;
    if (load && reset_ni) req_ready_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      grant_idx_o <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      mem_valid_o <= 1'b1;
      mem_addr_o  <= addr_v[win];
      mem_data_o  <= data_v[win];
      grant_idx_o <= win;
      rr_ptr      <= win_nxt;
    end else if (mem_valid_o && mem_ready_i) begin
      mem_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                       write_count_o <= '0;
    else if (mem_valid_o && mem_ready_i) write_count_o <= write_count_o + cnt_width'(1);
  end

  // requesters must hold valid, address and data until acked
  for (genvar k = 0; k < num_req; k++) begin : g_hold
    a_hold: assert property (@(posedge clk_i) disable iff (!reset_ni)
      (req_valid_i[k] && !req_ready_o[k]) |=>
        (req_valid_i[k] && $stable(addr_v[k]) && $stable(data_v[k])));
  end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Randomized bench for mem_write_arbiter against a cycle-level behavioural
// model of the slot, the round-robin order and the write counter.
module tb_mem_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      valid;
  logic [AW-1:0]     addr [N];
  logic [DW-1:0]     data [N];
  logic [N*AW-1:0]   addr_bus;
  logic [N*DW-1:0]   data_bus;
  logic              mready;
  logic [N-1:0]      rdy;
  logic              mvalid;
  logic [AW-1:0]     maddr;
  logic [DW-1:0]     mdata;
  logic [1:0]        gidx;
  logic [CW-1:0]     wcnt;

  // model state
  bit            m_full;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_src, m_rr, m_cnt;
  bit [N-1:0]    acked;
  bit            refill;
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_bus = '0;
    data_bus = '0;
    for (int k = 0; k < N; k++) begin
      addr_bus[k*AW +: AW] = addr[k];
      data_bus[k*DW +: DW] = data[k];
    end
  end

  mem_write_arbiter #(.num_req(N), .mem_addr_width(AW), .width(DW), .cnt_width(CW)) dut (
    .clk_i(clk), .reset_ni(rst_n), .req_valid_i(valid), .req_addr_i(addr_bus),
    .req_data_i(data_bus), .req_ready_o(rdy), .mem_valid_o(mvalid), .mem_addr_o(maddr),
    .mem_data_o(mdata), .mem_ready_i(mready), .grant_idx_o(gidx), .write_count_o(wcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_full = 0; m_addr = '0; m_data = '0; m_src = 0; m_rr = 0; m_cnt = 0;
  endtask

  // entered right after a falling edge; returns on the next falling edge
  task automatic cycle(input bit rnd);
    int w;
    bit can;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++)
      if (acked[k]) begin
        if (!refill) valid[k] = 1'b0;
        acked[k] = 1'b0;
      end
    if (rnd) begin
      mready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++)
        if (!valid[k] && $urandom_range(0, 1) == 1) begin
          valid[k] = 1'b1;
          addr[k]  = AW'($urandom);
          data[k]  = $urandom;
        end
    end
    #1;
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && valid[(m_rr + i) % N]) w = (m_rr + i) % N;
    can = !m_full || mready;
    exp_rdy = (w >= 0 && can) ? N'(1) << w : '0;
    chk("req_ready", 32'(rdy), 32'(exp_rdy));
    chk("mem_valid", 32'(mvalid), 32'(m_full));
    chk("mem_addr", 32'(maddr), 32'(m_addr));
    chk("mem_data", mdata, m_data);
    chk("grant_idx", 32'(gidx), 32'(m_src));
    chk("write_count", 32'(wcnt), 32'(m_cnt));
    @(posedge clk);
    if (m_full && mready) m_cnt = (m_cnt + 1) % (1 << CW);
    if (w >= 0 && can) begin
      m_full = 1; m_addr = addr[w]; m_data = data[w]; m_src = w;
      m_rr = (w + 1) % N; acked[w] = 1'b1;
    end else if (m_full && mready) m_full = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) if (acked[k]) valid[k] = 1'b0;
    acked = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    refill = 0;
    mready = 1'b1;
    repeat (8) cycle(0);
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; mready = 1'b0; refill = 0; acked = '0;
    for (int k = 0; k < N; k++) begin addr[k] = '0; data[k] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mvalid), 0);
    chk("rst_count", 32'(wcnt), 0);
    chk("rst_ready", 32'(rdy), 0);
    rst_n = 1'b1;

    // idle after reset
    repeat (5) cycle(0);

    // single write from core 2
    valid[2] = 1'b1; addr[2] = 16'h0040; data[2] = 32'hDEADBEEF; mready = 1'b1;
    cycle(0);
    chk("t2_grant", 32'(gidx), 2);
    chk("t2_addr", 32'(maddr), 32'h40);
    cycle(0);
    chk("t2_count", 32'(wcnt), 1);

    // all cores continuously requesting: strict rotation, one write per cycle
    do_reset();
    for (int k = 0; k < N; k++) begin valid[k] = 1'b1; addr[k] = AW'(16'h10 + k); data[k] = $urandom; end
    refill = 1; mready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(0);
      chk("t3_order", 32'(gidx), 32'(i % N));
    end
    chk("t3_count", 32'(wcnt), 8);
    drain();

    // stall with core 1 in the slot, then core 3 wins from rr_ptr=2
    do_reset();
    valid[1] = 1'b1; addr[1] = 16'h1111; data[1] = 32'h11112222; mready = 1'b1;
    cycle(0);
    mready = 1'b0;
    valid[0] = 1'b1; addr[0] = 16'h0A0A; data[0] = 32'hA0A0A0A0;
    valid[3] = 1'b1; addr[3] = 16'h3B3B; data[3] = 32'h3B3B3B3B;
    repeat (3) begin
      cycle(0);
      chk("t4_stall_addr", 32'(maddr), 32'h1111);
    end
    mready = 1'b1;
    cycle(0);
    chk("t4_grant", 32'(gidx), 3);
    drain();

    // reset pulse while the slot is full and stalled
    do_reset();
    valid[1] = 1'b1; addr[1] = 16'h0101; data[1] = 32'h01010101; mready = 1'b0;
    cycle(0);
    valid[2] = 1'b1; addr[2] = 16'h0202; data[2] = 32'h02020202;
    cycle(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_valid", 32'(mvalid), 0);
    chk("t5_count", 32'(wcnt), 0);
    chk("t5_ready", 32'(rdy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mready = 1'b1;
    cycle(0);
    chk("t5_regrant", 32'(gidx), 2);
    drain();

    // single requester streaming 17 writes: counter wraps modulo 2^CW
    do_reset();
    valid[0] = 1'b1; addr[0] = 16'h00C0; data[0] = 32'hC0FFEE00; refill = 1; mready = 1'b1;
    repeat (18) cycle(0);
    chk("t6_wrap", 32'(wcnt), 1);
    drain();

    // randomized traffic and backpressure
    do_reset();
    repeat (600) cycle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
